// File: rtl/fsm_haz_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_haz_pkg
//  Purpose  : Shared types and pin-index constants for the hazard resolver:
//             FSM state encoding plus ui_in / uo_out bit positions.
//  Revision : 1.0  initial release
// ============================================================================
package fsm_haz_pkg;

    // State codes are visible on uo_out[2:0].
    typedef enum logic [2:0] {
        ST_NOR = 3'd0,
        ST_CON = 3'd1,
        ST_DAT = 3'd2,
        ST_STA = 3'd3,
        ST_FLS = 3'd4
    } haz_state_e;

    // ui_in bit positions
    localparam int c_UI_DATA = 7;
    localparam int c_UI_STR  = 6;
    localparam int c_UI_CTRL = 4;
    localparam int c_UI_FWRD = 3;
    localparam int c_UI_CRCT = 2;

    // uo_out bit positions
    localparam int c_UO_RESOLVED  = 7;
    localparam int c_UO_PC_FREEZE = 6;
    localparam int c_UO_DO_FLUSH  = 5;
    localparam int c_UO_STATE_MSB = 2;

endpackage : fsm_haz_pkg
`default_nettype wire

// File: rtl/haz_fsm_core.sv
`default_nettype none
// ============================================================================
//  Module   : haz_fsm_core
//  Purpose  : Moore FSM classifying control/data/store hazards. Owns the
//             state register and the shared STA/FLS down-counter.
//  Revision : 1.0  initial release
// ============================================================================
module haz_fsm_core
    import fsm_haz_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ctrl,
    input  logic       i_data,
    input  logic       i_str,
    input  logic       i_fwrd,
    input  logic       i_crct,
    output logic [2:0] o_state,
    output logic       o_resolved,
    output logic       o_pc_freeze,
    output logic       o_do_flush,
    output logic       o_haz_entry
);

    // Counter load values: the state is occupied for (load + 1) cycles.
    localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] c_STALL_LOAD = 3'(STALL_CYCLES - 1);

    haz_state_e r_state;
    haz_state_e w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;

    // State and counter registers; reset aborts any stall or flush at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_NOR;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt = ST_NOR;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_NOR: begin
                // Priority: branch, then unforwarded data hazard, then store.
                if (i_ctrl) begin
                    w_state_nxt = ST_CON;
                end else if (i_data && !i_fwrd) begin
                    w_state_nxt = ST_DAT;
                end else if (i_str) begin
                    w_state_nxt = ST_STA;
                    w_cnt_nxt   = c_STALL_LOAD;
                end else begin
                    w_state_nxt = ST_NOR;
                end
            end
            ST_CON: begin
                if (i_crct) begin
                    w_state_nxt = ST_NOR;
                end else begin
                    w_state_nxt = ST_FLS;
                    w_cnt_nxt   = c_FLUSH_LOAD;
                end
            end
            ST_DAT: begin
                w_state_nxt = (i_fwrd || !i_data) ? ST_NOR : ST_DAT;
            end
            ST_STA, ST_FLS: begin
                // Inputs are ignored until the counter expires.
                if (r_cnt == 3'd0) begin
                    w_state_nxt = ST_NOR;
                end else begin
                    w_state_nxt = r_state;
                    w_cnt_nxt   = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_NOR;
            end
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        o_resolved  = 1'b0;
        o_pc_freeze = 1'b1;
        o_do_flush  = 1'b0;
        case (r_state)
            ST_CON, ST_DAT, ST_STA: begin
                o_pc_freeze = 1'b1;
            end
            ST_FLS: begin
                o_do_flush = 1'b1;
            end
            default: begin
                // NOR and the unused codes behave as normal flow.
                o_resolved  = 1'b1;
                o_pc_freeze = 1'b0;
            end
        endcase
    end

    assign o_state = r_state;

    // Only NOR can enter CON, DAT or STA, so any departure from NOR is an entry.
    assign o_haz_entry = (r_state == ST_NOR) && (w_state_nxt != ST_NOR);

endmodule : haz_fsm_core
`default_nettype wire

// File: rtl/fsm_haz_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_haz_resolver
//  Purpose  : Tiny Tapeout wrapper for the pipeline hazard resolver. Maps
//             pins onto haz_fsm_core and optionally counts hazard entries.
//  Options  : HAZ_CNT_EN - 8-bit saturating hazard-entry counter on uio_out.
//  Revision : 1.0  initial release
// ============================================================================
module fsm_haz_resolver
    import fsm_haz_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [2:0] w_state;
    logic       w_resolved;
    logic       w_pc_freeze;
    logic       w_do_flush;
    logic       w_haz_entry;

    haz_fsm_core #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ctrl      (ui_in[c_UI_CTRL]),
        .i_data      (ui_in[c_UI_DATA]),
        .i_str       (ui_in[c_UI_STR]),
        .i_fwrd      (ui_in[c_UI_FWRD]),
        .i_crct      (ui_in[c_UI_CRCT]),
        .o_state     (w_state),
        .o_resolved  (w_resolved),
        .o_pc_freeze (w_pc_freeze),
        .o_do_flush  (w_do_flush),
        .o_haz_entry (w_haz_entry)
    );

    always_comb begin
        uo_out                              = 8'h00;
        uo_out[c_UO_RESOLVED]               = w_resolved;
        uo_out[c_UO_PC_FREEZE]              = w_pc_freeze;
        uo_out[c_UO_DO_FLUSH]               = w_do_flush;
        uo_out[c_UO_STATE_MSB:0]            = w_state;
    end

`ifdef HAZ_CNT_EN
    logic [7:0] r_haz_cnt;

    // Saturating count of entries into CON, DAT or STA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_haz_cnt <= 8'h00;
        end else if (w_haz_entry && (r_haz_cnt != 8'hFF)) begin
            r_haz_cnt <= r_haz_cnt + 8'd1;
        end
    end

    assign uio_out = r_haz_cnt;
    assign uio_oe  = 8'hFF;

    logic w_unused;
    assign w_unused = &{1'b0, ena, uio_in, ui_in[5], ui_in[1:0]};
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic w_unused;
    assign w_unused = &{1'b0, ena, uio_in, ui_in[5], ui_in[1:0], w_haz_entry};
`endif

endmodule : fsm_haz_resolver
`default_nettype wire

// File: tb/tb_fsm_haz_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsm_haz_resolver
//  Purpose  : Self-checking bench for fsm_haz_resolver: directed scenarios
//             followed by randomized stimulus against a behavioural model.
//  Options  : HAZ_CNT_EN - also checks the hazard-entry counter on uio_out.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fsm_haz_resolver;

    localparam int FLUSH_CYCLES = 2;
    localparam int STALL_CYCLES = 1;

    // Model state names (plain integers, independent of the RTL encoding).
    localparam int M_NOR = 0;
    localparam int M_CON = 1;
    localparam int M_DAT = 2;
    localparam int M_STA = 3;
    localparam int M_FLS = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks;
    int n_errors;

    // Behavioural model: current state, a queue of states the pipeline is
    // committed to regardless of input, and the hazard-entry tally.
    int m_st;
    int m_sched[$];
    int m_cnt;

    fsm_haz_resolver #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .STALL_CYCLES (STALL_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_uo(input int st);
        case (st)
            M_CON:   return 8'h41;
            M_DAT:   return 8'h42;
            M_STA:   return 8'h43;
            M_FLS:   return 8'h64;
            default: return 8'h80;
        endcase
    endfunction

    task automatic model_reset();
        m_st = M_NOR;
        m_sched.delete();
        m_cnt = 0;
    endtask

    task automatic model_step(input logic [7:0] u);
        int nxt;
        bit ctrl, data, str, fwrd, crct;
        ctrl = u[4]; data = u[7]; str = u[6]; fwrd = u[3]; crct = u[2];
        if (m_sched.size() > 0) begin
            nxt = m_sched.pop_front();
        end else begin
            case (m_st)
                M_CON: begin
                    if (crct) nxt = M_NOR;
                    else begin
                        nxt = M_FLS;
                        for (int k = 1; k < FLUSH_CYCLES; k++) m_sched.push_back(M_FLS);
                        m_sched.push_back(M_NOR);
                    end
                end
                M_DAT: nxt = (data && !fwrd) ? M_DAT : M_NOR;
                default: begin
                    if (ctrl) nxt = M_CON;
                    else if (data && !fwrd) nxt = M_DAT;
                    else if (str) begin
                        nxt = M_STA;
                        for (int k = 1; k < STALL_CYCLES; k++) m_sched.push_back(M_STA);
                        m_sched.push_back(M_NOR);
                    end else nxt = M_NOR;
                end
            endcase
        end
        if (nxt != m_st && (nxt == M_CON || nxt == M_DAT || nxt == M_STA) && m_cnt < 255)
            m_cnt++;
        m_st = nxt;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".uo_out"}, {24'd0, uo_out}, {24'd0, exp_uo(m_st)});
`ifdef HAZ_CNT_EN
        check({tag, ".uio_out"}, {24'd0, uio_out}, m_cnt);
        check({tag, ".uio_oe"}, {24'd0, uio_oe}, 32'hFF);
`else
        check({tag, ".uio_out"}, {24'd0, uio_out}, 32'h0);
        check({tag, ".uio_oe"}, {24'd0, uio_oe}, 32'h0);
`endif
    endtask

    // One clock: apply input, let the edge happen, update model, compare.
    task automatic step(input logic [7:0] u, input string tag);
        ui_in = u;
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_step(u);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ui_in = 8'h00;
        #1;
        model_reset();
        check_outputs("rst_async");
        repeat (3) step(8'h00, "rst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] u;
        n_checks = 0;
        n_errors = 0;
        ena      = 1'b1;
        uio_in   = 8'h00;
        ui_in    = 8'h00;
        rst_n    = 1'b0;
        model_reset();

        // Reset behaviour
        do_reset();

        // Mispredicted branch: CON, FLS, FLS, NOR, CON
        for (int i = 0; i < 5; i++) step(8'h10, "branch_miss");
        check("branch_miss.literal", {24'd0, uo_out}, 32'h41);

        // Correctly predicted branch: CON/NOR alternating
        do_reset();
        for (int i = 0; i < 6; i++) step(8'h14, "branch_ok");

        // Data hazard held, then forwarded
        do_reset();
        for (int i = 0; i < 4; i++) step(8'h80, "data_hold");
        check("data_hold.literal", {24'd0, uo_out}, 32'h42);
        step(8'h88, "data_fwd");
        for (int i = 0; i < 3; i++) step(8'h88, "fwd_only");

        // Store stall repeating, then priority of ctrl
        do_reset();
        for (int i = 0; i < 5; i++) step(8'h40, "store");
        step(8'h00, "store_drain");
        step(8'hDC, "priority");
        check("priority.literal", {24'd0, uo_out}, 32'h41);

        // Async reset mid-flush
        do_reset();
        step(8'h10, "pre_fls");
        step(8'h10, "in_fls");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_mid_fls");
        step(8'h00, "rst_mid_fls_hold");
        rst_n = 1'b1;

        // Randomized stimulus with occasional asynchronous resets
        for (int i = 0; i < 800; i++) begin
            u = 8'($urandom);
            if ($urandom_range(0, 3) != 0) u[4] = 1'b0;
            if ($urandom_range(0, 60) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_outputs("rand_rst");
                #1;
                rst_n = 1'b1;
            end
            step(u, "rand");
        end

        // Long run of correct branches to drive the counter to saturation
        for (int i = 0; i < 560; i++) step(8'h14, "saturate");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fsm_haz_resolver
`default_nettype wire
